// File: rtl/video_mix_pkg.sv
// Shared definitions for the video_mix memory arbiter: owner codes,
// arbiter state encoding and default tuning constants.
package video_mix_pkg;

  // Owner code published on arb_state.
  typedef enum logic [1:0] {
    ARB_RD   = 2'b00,
    ARB_WR0  = 2'b01,
    ARB_WR1  = 2'b10,
    ARB_NONE = 2'b11
  } arb_code_t;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10,
    ST_GAP     = 2'b11
  } arb_fsm_t;

  localparam int DEF_TIMEOUT   = 4096;
  localparam int DEF_TO_W      = 13;
  localparam int DEF_GAP       = 2;
  localparam int DEF_RD_STARVE = 3;

endpackage

// File: rtl/video_mem_arb_if.sv
// Handshake bundle between the video_mix engines and the MCB arbiter.
// master = arbiter side, slave = engine/MCB side.
interface video_mem_arb_if;
  logic       rd_req;
  logic       rd_en;
  logic       rd_donep;
  logic [1:0] wr_req;
  logic [1:0] wr_en;
  logic [1:0] wr_donep;
  logic       mcb_cmd_empty;
  logic [1:0] arb_state;
  logic       timeout_err;
  logic [1:0] starve_cnt;

  modport master (
    input  rd_req, rd_donep, wr_req, wr_donep, mcb_cmd_empty,
    output rd_en, wr_en, arb_state, timeout_err, starve_cnt
  );

  modport slave (
    output rd_req, rd_donep, wr_req, wr_donep, mcb_cmd_empty,
    input  rd_en, wr_en, arb_state, timeout_err, starve_cnt
  );
endinterface

// File: rtl/video_arb_pick.sv
// Combinational winner selection. A client whose done strobe is still high
// is treated as not requesting, so a finished engine is never re-granted
// on its own trailing done.
module video_arb_pick
  import video_mix_pkg::*;
#(
  parameter int RD_STARVE = DEF_RD_STARVE
) (
  input  logic       rd_req,
  input  logic       rd_donep,
  input  logic [1:0] wr_req,
  input  logic [1:0] wr_donep,
  input  logic       rr_ptr,      // 0 = WR0 next, 1 = WR1 next
  input  logic [1:0] starve_cnt,
  output logic       valid,
  output arb_code_t  winner
);

  logic       rd_ok;
  logic [1:0] wr_ok;

  // Read wins when alone or when it has been starved long enough;
  // otherwise writes are served round robin starting at rr_ptr.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid  = 1'b0;
    winner = ARB_NONE;
    rd_ok  = rd_req & ~rd_donep;
    wr_ok  = wr_req & ~wr_donep;

    if (rd_ok && ((wr_ok == 2'b00) || (starve_cnt == 2'(RD_STARVE)))) begin
      valid  = 1'b1;
      winner = ARB_RD;
    end else if (wr_ok[rr_ptr]) begin
      valid  = 1'b1;
      winner = rr_ptr ? ARB_WR1 : ARB_WR0;
    end else if (wr_ok[~rr_ptr]) begin
      valid  = 1'b1;
      winner = rr_ptr ? ARB_WR0 : ARB_WR1;
    end
  end

endmodule

// File: rtl/video_mem_arb.sv
// MCB port arbiter for the video_mix engines: one display read engine and
// two camera write engines. Exactly one memcon_en is held high per grant
// until the owner's done handshake (or a timeout) ends it, then the MCB
// command FIFO is allowed to drain before the next owner is picked.
module video_mem_arb
  import video_mix_pkg::*;
#(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TO_W      = DEF_TO_W,
  parameter int GAP       = DEF_GAP,
  parameter int RD_STARVE = DEF_RD_STARVE
) (
  input  logic            memclk,
  input  logic            mem_rst_n,
  video_mem_arb_if.master bus
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  arb_fsm_t         state_q,   state_d;
  arb_code_t        arb_q,     arb_d;
  logic             rd_en_q,   rd_en_d;
  logic [1:0]       wr_en_q,   wr_en_d;
  logic             terr_q,    terr_d;
  logic [1:0]       starve_q,  starve_d;
  logic             rr_q,      rr_d;
  logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic      pick_valid;
  arb_code_t pick_winner;
  logic      owner_donep;

  video_arb_pick #(
    .RD_STARVE(RD_STARVE)
  ) u_pick (
    .rd_req    (bus.rd_req),
    .rd_donep  (bus.rd_donep),
    .wr_req    (bus.wr_req),
    .wr_donep  (bus.wr_donep),
    .rr_ptr    (rr_q),
    .starve_cnt(starve_q),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  // Done strobe of the current owner only; other clients' strobes are ignored.
  always_comb begin
    owner_donep = 1'b0;
    case (arb_q)
      ARB_RD:  owner_donep = bus.rd_donep;
      ARB_WR0: owner_donep = bus.wr_donep[0];
      ARB_WR1: owner_donep = bus.wr_donep[1];
      default: owner_donep = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the grant sequencer.
  always_comb begin
    state_d   = state_q;
    arb_d     = arb_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    terr_d    = 1'b0;
    starve_d  = starve_q;
    rr_d      = rr_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        arb_d = ARB_NONE;
        if (pick_valid) begin
          state_d  = ST_GRANT;
          arb_d    = pick_winner;
          rd_en_d  = (pick_winner == ARB_RD);
          wr_en_d  = {pick_winner == ARB_WR1, pick_winner == ARB_WR0};
          to_cnt_d = '0;
          if (pick_winner == ARB_RD) begin
            starve_d = 2'd0;
          end else begin
            if (bus.rd_req && (starve_q != 2'(RD_STARVE)))
              starve_d = starve_q + 2'd1;
            // Next round starts at the engine that did not just win.
            rr_d = (pick_winner == ARB_WR0);
          end
        end
      end

      ST_GRANT: begin
        if (owner_donep) begin
          rd_en_d = 1'b0;
          wr_en_d = 2'b00;
          state_d = ST_RELEASE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          rd_en_d = 1'b0;
          wr_en_d = 2'b00;
          terr_d  = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_RELEASE: begin
        // Owner must have finished its handshake and the MCB must have
        // drained its commands before anyone else may issue.
        if (bus.mcb_cmd_empty && !owner_donep) begin
          arb_d     = ARB_NONE;
          gap_cnt_d = '0;
          state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (int'(gap_cnt_q) >= GAP - 1) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge memclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!mem_rst_n) begin
      state_q   <= ST_IDLE;
      arb_q     <= ARB_NONE;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 2'b00;
      terr_q    <= 1'b0;
      starve_q  <= 2'd0;
      rr_q      <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arb_q     <= arb_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      terr_q    <= terr_d;
      starve_q  <= starve_d;
      rr_q      <= rr_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.arb_state   = arb_q;
  assign bus.timeout_err = terr_q;
  assign bus.starve_cnt  = starve_q;

endmodule

// File: doc/video_mem_arb.md
Name: video_mem_arb

Overview:
- Sequences the shared MCB port among three bursting clients: one display read engine and two camera write engines (WR0 = left eye, WR1 = right eye).
- Grants exactly one client at a time by holding that client's memcon_en high until its done handshake completes.
- Publishes the current owner on arb_state; read engines may issue MCB commands only while arb_state == 2'b00.
- Sits in the memclk domain, between the video_mix read/write engines and the MCB port.

Parameters:
- TIMEOUT, 4096, memclk cycles a grant may stay open before it is forcibly revoked.
- TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.
- GAP, 2, idle cycles inserted between a release and the next grant (0 allowed).
- RD_STARVE, 3, maximum consecutive write grants allowed while rd_req is pending.

Ports:
- memclk  in  1  memory clock; all logic sits on the rising edge.
- mem_rst_n  in  1  synchronous, active-low reset.
- rd_req  in  1  read engine needs a line (display FIFO below threshold); level.
- rd_en  out  1  memcon_en to read engine.
- rd_donep  in  1  memcon_donep from read engine; high for ≥1 cycle after line done, may stay high several cycles.
- wr_req  in  2  per write engine: input FIFO holds ≥1 burst; level.
- wr_en  out  2  memcon_en to write engines.
- wr_donep  in  2  done from write engines; same semantics as rd_donep.
- mcb_cmd_empty  in  1  MCB command FIFO empty.
- arb_state  out  2  owner: 00 = READ, 01 = WR0, 10 = WR1, 11 = none.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.
- starve_cnt  out  2  current count of consecutive write grants while rd_req is pending; for debug.

Behaviour:
- Reset values, while mem_rst_n == 0 at a clock edge: state = IDLE, rd_en = 0, wr_en = 0, arb_state = 11, timeout_err = 0, starve_cnt = 0, rr_ptr = WR0, timeout counter = 0, gap counter = 0.
- States: IDLE, GRANT, RELEASE, GAP.
- IDLE: evaluate requests, masking any client whose donep is still high.
  - Read wins if rd_req is set and either no write request is pending or starve_cnt == RD_STARVE.
  - Otherwise, if starve_cnt < RD_STARVE, the write requester at rr_ptr wins; if it is not requesting, the other write requester wins.
  - If only rd_req is pending, read wins regardless of starve_cnt.
  - Winner gets its en = 1 and arb_state = its code on the next cycle; go to GRANT.
  - No requests: stay in IDLE, arb_state = 11.
- GRANT:
  - en is held high and the timeout counter increments each cycle.
  - Owner's donep sampled high: drop en the next cycle and go to RELEASE.
  - Counter reaches TIMEOUT - 1 without donep: drop en, pulse timeout_err for one cycle, go to RELEASE.
  - arb_state keeps the owner code through GRANT and RELEASE.
- RELEASE:
  - Wait until mcb_cmd_empty == 1 and the owner's donep == 0, both sampled in the same cycle.
  - Then set arb_state = 11 and go to GAP; if GAP == 0, go directly to IDLE.
- GAP: count GAP cycles, then go to IDLE.
- Bookkeeping on every grant:
  - Write grant with rd_req high at grant time: starve_cnt increments, saturating at RD_STARVE.
  - Read grant: starve_cnt clears to 0.
  - Write grant: rr_ptr toggles to the other write engine.
  - Timeout counter clears on every grant.
- Latency: request to en is 1 cycle from IDLE. Release to next en is RELEASE duration + GAP + 1 cycles.
- Corner cases:
  - Simultaneous rd_req and wr_req with starve_cnt < RD_STARVE goes to the write side (round robin).
  - Request deasserting during GRANT has no effect; only donep or timeout ends a grant.
  - donep from a non-owner is ignored.
  - Reset mid-grant: all en drop within one cycle and state returns to IDLE.
  - At most one en bit may be high in any cycle (onehot0 over {rd_en, wr_en}).

Decomposition:
- Shared package video_mix_pkg holds:
  - arb_state codes ARB_RD, ARB_WR0, ARB_WR1, ARB_NONE;
  - arbiter state encoding;
  - default TIMEOUT and GAP.
- One natural sub-module, video_arb_pick: combinational winner selection from rd_req, wr_req, rr_ptr, starve_cnt and the donep masks, returning a valid flag and the winner code.

Test Plan:
- rd_req = 1 only; rd_donep pulses 20 cycles after grant -> rd_en rises 1 cycle after request, arb_state = 00, rd_en falls the cycle after rd_donep, arb_state = 11 after cmd_empty, GAP = 2 cycles observed.
- wr_req = 2'b11 held, rd_req = 0, each client done after 10 cycles -> grants alternate WR0, WR1, WR0, WR1; arb_state sequence 01, 10, 01, 10.
- wr_req = 2'b11 and rd_req = 1 held -> exactly 3 write grants (01, 10, 01), then the 4th grant is READ (00), after which starve_cnt = 0.
- Owner never asserts donep -> en drops at cycle 4096 of the grant, timeout_err pulses exactly once, next grant follows normally.
- rd_donep held high 5 cycles with mcb_cmd_empty = 0 for 8 cycles -> stays in RELEASE until both conditions clear; rd_req not regranted while rd_donep is high.
- mem_rst_n = 0 asserted mid-grant -> rd_en = wr_en = 0 and arb_state = 11 on the next edge; after release, the first request is granted normally with rr_ptr = WR0.
